// File: rtl/unbalanced_fifo_ctrl_pkg.sv
// Shared helpers for the wide-to-narrow FIFO controller and its RAM.
// Read latency and subword count are derived from parameters in one place.
package unbalanced_fifo_ctrl_pkg;

    function automatic int rl_of(input string perf);
        return (perf == "HIGH_PERFORMANCE") ? 2 : 1;
    endfunction

    function automatic int iters_of(input int width_factor);
        return 1 << width_factor;
    endfunction

endpackage

// File: rtl/unbalanced_ram.sv
// Unbalanced dual-port RAM: wide write on port A, narrow read on port B.
// Port B output has one register (LOW_LATENCY) or two (HIGH_PERFORMANCE).
module unbalanced_ram
    import unbalanced_fifo_ctrl_pkg::*;
#(
    parameter int    DATA_WIDTH_A    = 64,
    parameter int    ADDR_WIDTH_A    = 7,
    parameter int    WIDTH_FACTOR    = 1,
    parameter string RAM_PERFORMANCE = "LOW_LATENCY",
    parameter int    DATA_WIDTH_B    = DATA_WIDTH_A >> WIDTH_FACTOR,
    parameter int    ADDR_WIDTH_B    = ADDR_WIDTH_A + WIDTH_FACTOR
) (
    input  logic                    clka,
    input  logic                    ena,
    input  logic                    wea,
    input  logic [ADDR_WIDTH_A-1:0] addra,
    input  logic [DATA_WIDTH_A-1:0] dina,
    input  logic                    clkb,
    input  logic                    enb,
    input  logic [ADDR_WIDTH_B-1:0] addrb,
    input  logic                    regceb,
    input  logic                    rstb,
    output logic [DATA_WIDTH_B-1:0] doutb
);
    localparam int ITERS = iters_of(WIDTH_FACTOR);
    localparam int RL    = rl_of(RAM_PERFORMANCE);

    logic [ITERS-1:0][DATA_WIDTH_B-1:0] r_mem [2**ADDR_WIDTH_A];
    logic [DATA_WIDTH_B-1:0]            r_lat;

    always_ff @(posedge clka) begin
        if (ena && wea)
            r_mem[addra] <= dina;
    end

    always_ff @(posedge clkb) begin
        if (rstb)
            r_lat <= '0;
        else if (enb)
            r_lat <= r_mem[addrb[ADDR_WIDTH_B-1:WIDTH_FACTOR]][addrb[WIDTH_FACTOR-1:0]];
    end

    if (RL == 2) begin : g_hp
        logic [DATA_WIDTH_B-1:0] r_out;
        always_ff @(posedge clkb) begin
            if (rstb)
                r_out <= '0;
            else if (regceb)
                r_out <= r_lat;
        end
        assign doutb = r_out;
    end else begin : g_ll
        // regceb doubles as an output enable when there is no output register
        assign doutb = regceb ? r_lat : '0;
    end

endmodule

// File: rtl/unbalanced_fifo_ctrl.sv
// Wide-to-narrow FIFO controller: wide words in, LSB-first subwords out.
// Tracks RAM read latency and lands returning data in a small skid FIFO.
module unbalanced_fifo_ctrl
    import unbalanced_fifo_ctrl_pkg::*;
#(
    parameter int    DATA_WIDTH_A    = 64,
    parameter int    ADDR_WIDTH_A    = 7,
    parameter int    WIDTH_FACTOR    = 1,
    parameter string RAM_PERFORMANCE = "LOW_LATENCY",
    parameter int    DATA_WIDTH_B    = DATA_WIDTH_A >> WIDTH_FACTOR,
    parameter int    ADDR_WIDTH_B    = ADDR_WIDTH_A + WIDTH_FACTOR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [DATA_WIDTH_A-1:0] din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [DATA_WIDTH_B-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [ADDR_WIDTH_B:0]   count,
    output logic                    full,
    output logic                    empty
);
    localparam int RL  = rl_of(RAM_PERFORMANCE);
    localparam int SKW = $clog2(RL + 2);
    localparam int SKN = 2 ** SKW;

    logic [ADDR_WIDTH_A:0]   r_wr_ptr;
    logic [ADDR_WIDTH_B:0]   r_rd_ptr;
    logic [RL-1:0]           r_pipe;
    logic [DATA_WIDTH_B-1:0] r_skid [SKN];
    logic [SKW-1:0]          r_head;
    logic [SKW-1:0]          r_tail;
    logic [SKW-1:0]          r_skid_cnt;

    logic [SKW-1:0]          w_inflight;
    logic [SKW:0]            w_occ;
    logic [ADDR_WIDTH_A:0]   w_wide_used;
    logic [DATA_WIDTH_B-1:0] w_doutb;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_push;
    logic                    w_pop;

    assign count       = {r_wr_ptr, {WIDTH_FACTOR{1'b0}}} - r_rd_ptr;
    assign w_wide_used = r_wr_ptr - r_rd_ptr[ADDR_WIDTH_B:WIDTH_FACTOR];
    assign full        = (w_wide_used == {1'b1, {ADDR_WIDTH_A{1'b0}}});
    assign empty       = (count == '0);
    assign din_ready   = !full;
    assign dout_valid  = (r_skid_cnt != '0);
    assign dout        = r_skid[r_head];

    assign w_wr   = din_valid && !full && !flush;
    assign w_pop  = dout_valid && dout_ready;
    assign w_push = r_pipe[RL-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RL; i++)
            w_inflight = w_inflight + SKW'(r_pipe[i]);
    end

    // A pop this cycle frees a slot before any newly issued read can land
    assign w_occ = {1'b0, r_skid_cnt} + {1'b0, w_inflight} - (SKW+1)'(w_pop);
    assign w_rd  = !empty && (w_occ < (SKW+1)'(RL + 1)) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pipe     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_skid_cnt <= '0;
            for (int i = 0; i < SKN; i++)
                r_skid[i] <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pipe     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_skid_cnt <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH_A+1)'(1);
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + (ADDR_WIDTH_B+1)'(1);
            r_pipe[0] <= w_rd;
            for (int i = 1; i < RL; i++)
                r_pipe[i] <= r_pipe[i-1];
            if (w_push) begin
                r_skid[r_tail] <= w_doutb;
                r_tail         <= r_tail + SKW'(1);
            end
            if (w_pop)
                r_head <= r_head + SKW'(1);
            r_skid_cnt <= r_skid_cnt + SKW'(w_push) - SKW'(w_pop);
        end
    end

    unbalanced_ram #(
        .DATA_WIDTH_A    (DATA_WIDTH_A),
        .ADDR_WIDTH_A    (ADDR_WIDTH_A),
        .WIDTH_FACTOR    (WIDTH_FACTOR),
        .RAM_PERFORMANCE (RAM_PERFORMANCE)
    ) u_ram (
        .clka   (clk),
        .ena    (w_wr),
        .wea    (1'b1),
        .addra  (r_wr_ptr[ADDR_WIDTH_A-1:0]),
        .dina   (din),
        .clkb   (clk),
        .enb    (w_rd),
        .addrb  (r_rd_ptr[ADDR_WIDTH_B-1:0]),
        .regceb (1'b1),
        .rstb   (1'b0),
        .doutb  (w_doutb)
    );

endmodule
